// File: rtl/netwalk_exec_pkg.sv
// rtl/netwalk_exec_pkg.sv - shared constants and helpers for the action execution pipe
//
// Purpose: action-flag bit positions, default geometry of the header and
// set-field value, and a constant-evaluable clog2 used for derived widths.
// Ports: none (package).

package netwalk_exec_pkg;

  // Bit positions inside the 4-bit action flag word; bit 3 is reserved.
  localparam int ACT_SET_FIELD = 0;
  localparam int ACT_DEC_TTL   = 1;
  localparam int ACT_DROP      = 2;

  // Untagged Ethernet + IPv4 header geometry.
  localparam int DEF_HDR_W   = 512;
  localparam int DEF_FIELD_W = 48;
  localparam int DEF_TTL_OFF = 22;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/netwalk_sync_fifo.sv
// rtl/netwalk_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
//
// Purpose: buffers rewritten headers for the egress scheduler. The head is
// presented combinationally from storage, but an entry only becomes visible
// on rd_valid one edge after it was written.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   wr_valid, wr_data  write strobe and data (caller never writes when full)
//   rd_valid, rd_ready head valid / head consumed
//   rd_data            head entry, zero while rd_valid is low
//   count              stored entries, including a not-yet-visible one

module netwalk_sync_fifo
  import netwalk_exec_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [W-1:0]     wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] kept;
  logic             pop;

  assign pop = valid_q && rd_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_valid) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(wr_valid) - CNT_W'(pop);
    // Only entries that were already stored before this edge become
    // visible, which gives a freshly written entry one cycle of latency.
    kept    = count_q - CNT_W'(pop);
    valid_d = (kept != '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/netwalk_action_exec_pipe.sv
// rtl/netwalk_action_exec_pipe.sv - two-stage header action pipe feeding an egress FIFO
//
// Purpose: applies set-field, TTL decrement and drop, in that order, to one
// header per handshake and queues surviving headers with their egress port.
// Upstream flow control is a registered credit check over everything held
// in S1, S2 and the FIFO.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          ingress handshake
//   in_flag                    [0] set_field [1] dec_ttl [2] drop [3] reserved
//   in_hdr, in_set_off,
//   in_set_val, in_out_port    header, set-field byte offset/value, egress port
//   out_valid/out_ready        egress handshake (FIFO head)
//   out_hdr, out_port          head header and port
//   drop_cnt                   saturating dropped-packet counter
//   err_pulse                  set-field range error or TTL expiry

module netwalk_action_exec_pipe
  import netwalk_exec_pkg::*;
#(
  parameter int HDR_W   = DEF_HDR_W,
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int TTL_OFF = DEF_TTL_OFF,
  parameter int PORT_W  = 4,
  parameter int DEPTH   = 4,
  localparam int OFF_W  = clog2(HDR_W / 8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_flag,
  input  logic [HDR_W-1:0]   in_hdr,
  input  logic [OFF_W-1:0]   in_set_off,
  input  logic [FIELD_W-1:0] in_set_val,
  input  logic [PORT_W-1:0]  in_out_port,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HDR_W-1:0]   out_hdr,
  output logic [PORT_W-1:0]  out_port,
  output logic [15:0]        drop_cnt,
  output logic               err_pulse
);

  localparam int NB    = HDR_W / 8;
  localparam int FB    = FIELD_W / 8;
  localparam int HB_W  = clog2(HDR_W);
  localparam int VB_W  = clog2(FIELD_W);
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int TTL_HI = HDR_W - 1 - 8 * TTL_OFF;

  // Reserved flag bit carries no meaning in this stage.
  logic flag_rsvd_unused;
  assign flag_rsvd_unused = in_flag[3];

  // Stage S1 registers.
  logic               v1_q, v1_d;
  logic [2:0]         flag1_q, flag1_d;
  logic [HDR_W-1:0]   hdr1_q, hdr1_d;
  logic [OFF_W-1:0]   off1_q, off1_d;
  logic [FIELD_W-1:0] val1_q, val1_d;
  logic [PORT_W-1:0]  port1_q, port1_d;

  // Stage S2 registers.
  logic               v2_q, v2_d;
  logic               drop2_q, drop2_d;
  logic [HDR_W-1:0]   hdr2_q, hdr2_d;
  logic [PORT_W-1:0]  port2_q, port2_d;

  logic               in_ready_q, in_ready_d;
  logic               err_pulse_q, err_pulse_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  // S2 combinational results.
  logic [HDR_W-1:0]   hdr_set;
  logic [HDR_W-1:0]   hdr_res;
  logic [7:0]         ttl;
  logic               set_err;
  logic               ttl_exp;
  logic               drop_now;
  logic [HB_W-1:0]    wr_pos;
  logic [VB_W-1:0]    rd_pos;

  // Flow control.
  logic               accept;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [OCC_W-1:0]   occ_next;
  logic               fifo_valid;
  logic [HDR_W+PORT_W-1:0] fifo_rd_data;

  assign accept = in_valid && in_ready_q;
  assign push   = v2_q && !drop2_q;
  assign pop    = fifo_valid && out_ready;

  always_comb begin
    hdr_set = hdr1_q;
    set_err = 1'b0;
    wr_pos  = '0;
    rd_pos  = '0;
    if (flag1_q[ACT_SET_FIELD]) begin
      if (int'(off1_q) + FB <= NB) begin
        for (int j = 0; j < FB; j++) begin
          wr_pos = HB_W'(HDR_W - 1 - 8 * (int'(off1_q) + j));
          rd_pos = VB_W'(FIELD_W - 1 - 8 * j);
          hdr_set[wr_pos -: 8] = val1_q[rd_pos -: 8];
        end
      end else begin
        set_err = 1'b1;
      end
    end

    // TTL sees the header after any set-field rewrite.
    hdr_res = hdr_set;
    ttl     = hdr_set[TTL_HI -: 8];
    ttl_exp = 1'b0;
    if (flag1_q[ACT_DEC_TTL]) begin
      if (ttl != 8'd0) begin
        hdr_res[TTL_HI -: 8] = ttl - 8'd1;
      end else begin
        ttl_exp = 1'b1;
      end
    end
    drop_now = ttl_exp || flag1_q[ACT_DROP];
  end

  always_comb begin
    v1_d    = accept;
    flag1_d = accept ? in_flag[2:0] : flag1_q;
    hdr1_d  = accept ? in_hdr       : hdr1_q;
    off1_d  = accept ? in_set_off   : off1_q;
    val1_d  = accept ? in_set_val   : val1_q;
    port1_d = accept ? in_out_port  : port1_q;

    v2_d    = v1_q;
    drop2_d = v1_q && drop_now;
    hdr2_d  = v1_q ? hdr_res : hdr2_q;
    port2_d = v1_q ? port1_q : port2_q;

    // Both error sources on one packet collapse into a single pulse.
    err_pulse_d = v1_q && (set_err || ttl_exp);

    // Counted when the dropped packet leaves S2 and releases its credit.
    drop_cnt_d = drop_cnt_q;
    if (v2_q && drop2_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Credit is evaluated on post-edge occupancy so a packet accepted this
    // edge is already charged when in_ready is next presented.
    occ_next = OCC_W'(fifo_cnt) + OCC_W'(push) - OCC_W'(pop)
             + OCC_W'(v1_d) + OCC_W'(v2_d);
    in_ready_d = (occ_next < OCC_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      flag1_q     <= '0;
      hdr1_q      <= '0;
      off1_q      <= '0;
      val1_q      <= '0;
      port1_q     <= '0;
      v2_q        <= 1'b0;
      drop2_q     <= 1'b0;
      hdr2_q      <= '0;
      port2_q     <= '0;
      in_ready_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      flag1_q     <= flag1_d;
      hdr1_q      <= hdr1_d;
      off1_q      <= off1_d;
      val1_q      <= val1_d;
      port1_q     <= port1_d;
      v2_q        <= v2_d;
      drop2_q     <= drop2_d;
      hdr2_q      <= hdr2_d;
      port2_q     <= port2_d;
      in_ready_q  <= in_ready_d;
      err_pulse_q <= err_pulse_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  netwalk_sync_fifo #(
    .W     (HDR_W + PORT_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (push),
    .wr_data  ({hdr2_q, port2_q}),
    .rd_valid (fifo_valid),
    .rd_ready (out_ready),
    .rd_data  (fifo_rd_data),
    .count    (fifo_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = fifo_valid;
  assign out_hdr   = fifo_rd_data[HDR_W+PORT_W-1:PORT_W];
  assign out_port  = fifo_rd_data[PORT_W-1:0];
  assign drop_cnt  = drop_cnt_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_netwalk_action_exec_pipe.sv
// tb/tb_netwalk_action_exec_pipe.sv - directed self-checking bench for netwalk_action_exec_pipe

module tb_netwalk_action_exec_pipe;

  localparam int HDR_W   = 512;
  localparam int FIELD_W = 48;
  localparam int TTL_OFF = 22;
  localparam int PORT_W  = 4;
  localparam int DEPTH   = 8;
  localparam int OFF_W   = 6;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_flag;
  logic [HDR_W-1:0]   in_hdr;
  logic [OFF_W-1:0]   in_set_off;
  logic [FIELD_W-1:0] in_set_val;
  logic [PORT_W-1:0]  in_out_port;
  logic               out_valid;
  logic               out_ready;
  logic [HDR_W-1:0]   out_hdr;
  logic [PORT_W-1:0]  out_port;
  logic [15:0]        drop_cnt;
  logic               err_pulse;

  int errors = 0;
  int checks = 0;

  logic [HDR_W-1:0]   base;
  logic [FIELD_W-1:0] sval;

  netwalk_action_exec_pipe #(
    .HDR_W   (HDR_W),
    .FIELD_W (FIELD_W),
    .TTL_OFF (TTL_OFF),
    .PORT_W  (PORT_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_flag     (in_flag),
    .in_hdr      (in_hdr),
    .in_set_off  (in_set_off),
    .in_set_val  (in_set_val),
    .in_out_port (in_out_port),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hdr     (out_hdr),
    .out_port    (out_port),
    .drop_cnt    (drop_cnt),
    .err_pulse   (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one packet and observes eight negedges after the accept edge.
  task automatic send_obs(input logic [3:0] f, input logic [HDR_W-1:0] h,
                          input logic [OFF_W-1:0] off, input logic [FIELD_W-1:0] v,
                          input logic [PORT_W-1:0] p,
                          output int n_out, output int n_err, output int lat,
                          output logic [HDR_W-1:0] oh, output logic [PORT_W-1:0] op);
    int waitc;
    n_out = 0; n_err = 0; lat = 0; oh = '0; op = '0;
    @(negedge clk);
    in_flag = f; in_hdr = h; in_set_off = off; in_set_val = v; in_out_port = p;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got %b expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (err_pulse) n_err++;
        if (out_valid && out_ready) begin
          if (n_out == 0) begin
            lat = k; oh = out_hdr; op = out_port;
          end
          n_out++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_flag = '0; in_hdr = '0; in_set_off = '0; in_set_val = '0; in_out_port = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_hdr !== '0) begin errors++; $display("FAIL rst_out_hdr: got %h expected 0", out_hdr); end
    checks++; if (out_port !== '0) begin errors++; $display("FAIL rst_out_port: got %h expected 0", out_port); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse: got %b expected 0", err_pulse); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_passthrough();
    int n_out, n_err, lat;
    logic [HDR_W-1:0] oh;
    logic [PORT_W-1:0] op;
    send_obs(4'b0000, base, 6'd0, '0, 4'd3, n_out, n_err, lat, oh, op);
    checks++; if (n_out !== 1) begin errors++; $display("FAIL pass_count: got %0d expected 1", n_out); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL pass_latency: got %0d expected 4", lat); end
    checks++; if (oh !== base) begin errors++; $display("FAIL pass_hdr: got %h expected %h", oh, base); end
    checks++; if (op !== 4'd3) begin errors++; $display("FAIL pass_port: got %0d expected 3", op); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL pass_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL pass_err: got %0d expected 0", n_err); end
  endtask

  task automatic test_set_field();
    int n_out, n_err, lat;
    logic [HDR_W-1:0] oh, exp_h;
    logic [PORT_W-1:0] op;
    send_obs(4'b0001, base, 6'd0, sval, 4'd1, n_out, n_err, lat, oh, op);
    exp_h = {48'h0050569A0007, base[HDR_W-49:0]};
    checks++; if (oh !== exp_h) begin errors++; $display("FAIL setf_off0_hdr: got %h expected %h", oh, exp_h); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL setf_off0_err: got %0d expected 0", n_err); end
    // Last legal offset: bytes 58..63.
    send_obs(4'b0001, base, 6'd58, sval, 4'd1, n_out, n_err, lat, oh, op);
    exp_h = {base[HDR_W-1:48], 48'h0050569A0007};
    checks++; if (oh !== exp_h) begin errors++; $display("FAIL setf_off58_hdr: got %h expected %h", oh, exp_h); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL setf_off58_err: got %0d expected 0", n_err); end
    // Overflowing offset leaves the header and still forwards it.
    send_obs(4'b0001, base, 6'd60, sval, 4'd2, n_out, n_err, lat, oh, op);
    checks++; if (n_out !== 1) begin errors++; $display("FAIL setf_off60_count: got %0d expected 1", n_out); end
    checks++; if (oh !== base) begin errors++; $display("FAIL setf_off60_hdr: got %h expected %h", oh, base); end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL setf_off60_err: got %0d expected 1", n_err); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL setf_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_dec_ttl();
    int n_out, n_err, lat;
    logic [HDR_W-1:0] h, oh, exp_h;
    logic [PORT_W-1:0] op;
    h = base; h[335:328] = 8'h40;
    exp_h = base; exp_h[335:328] = 8'h3F;
    send_obs(4'b0010, h, 6'd0, '0, 4'd5, n_out, n_err, lat, oh, op);
    checks++; if (oh !== exp_h) begin errors++; $display("FAIL ttl_dec_hdr: got %h expected %h", oh, exp_h); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL ttl_dec_err: got %0d expected 0", n_err); end
    h[335:328] = 8'h00;
    send_obs(4'b0010, h, 6'd0, '0, 4'd5, n_out, n_err, lat, oh, op);
    checks++; if (n_out !== 0) begin errors++; $display("FAIL ttl_exp_count: got %0d expected 0", n_out); end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL ttl_exp_err: got %0d expected 1", n_err); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ttl_exp_drop_cnt: got %0d expected 1", drop_cnt); end
    // Set-field covers bytes 20..25, writing 0x56 into TTL before the decrement.
    exp_h = base; exp_h[351:304] = 48'h0050569A0007; exp_h[335:328] = 8'h55;
    send_obs(4'b0011, base, 6'd20, sval, 4'd6, n_out, n_err, lat, oh, op);
    checks++; if (oh !== exp_h) begin errors++; $display("FAIL ttl_after_setf_hdr: got %h expected %h", oh, exp_h); end
    checks++; if (op !== 4'd6) begin errors++; $display("FAIL ttl_after_setf_port: got %0d expected 6", op); end
    // Range error and expiry together: one pulse, one drop.
    send_obs(4'b0011, h, 6'd60, sval, 4'd6, n_out, n_err, lat, oh, op);
    checks++; if (n_err !== 1) begin errors++; $display("FAIL dual_err_pulse: got %0d expected 1", n_err); end
    checks++; if (n_out !== 0) begin errors++; $display("FAIL dual_err_count: got %0d expected 0", n_out); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL dual_err_drop_cnt: got %0d expected 2", drop_cnt); end
  endtask

  task automatic test_drop();
    int n_out, n_err, lat;
    logic [HDR_W-1:0] oh;
    logic [PORT_W-1:0] op;
    send_obs(4'b0101, base, 6'd0, sval, 4'd7, n_out, n_err, lat, oh, op);
    checks++; if (n_out !== 0) begin errors++; $display("FAIL drop_count: got %0d expected 0", n_out); end
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_drop_cnt: got %0d expected 3", drop_cnt); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL drop_err: got %0d expected 0", n_err); end
    send_obs(4'b1000, base, 6'd0, sval, 4'd8, n_out, n_err, lat, oh, op);
    checks++; if (oh !== base) begin errors++; $display("FAIL rsvd_hdr: got %h expected %h", oh, base); end
    checks++; if (op !== 4'd8) begin errors++; $display("FAIL rsvd_port: got %0d expected 8", op); end
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL rsvd_drop_cnt: got %0d expected 3", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    int acc;
    logic rdy;
    logic [HDR_W-1:0] exp_h;
    acc = 0;
    out_ready = 1'b0;
    in_flag = 4'b0000; in_set_off = '0; in_set_val = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      rdy = in_ready;
      in_valid = 1'b1;
      in_hdr = {base[HDR_W-1:8], 8'(acc)};
      in_out_port = 4'(acc);
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (acc !== DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    exp_h = {base[HDR_W-1:8], 8'd0};
    @(negedge clk);
    checks++; if (out_hdr !== exp_h) begin errors++; $display("FAIL bp_head_stable: got %h expected %h", out_hdr, exp_h); end
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      exp_h = {base[HDR_W-1:8], 8'(j)};
      checks++;
      if (out_valid !== 1'b1 || out_hdr !== exp_h || out_port !== 4'(j)) begin
        errors++;
        $display("FAIL bp_drain_%0d: got valid=%b port=%0d hdr=%h expected valid=1 port=%0d hdr=%h",
                 j, out_valid, out_port, out_hdr, j, exp_h);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_empty: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_midop();
    int seen_valid;
    out_ready = 1'b0;
    in_flag = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_hdr = {base[HDR_W-1:8], 8'(i + 16)};
      in_out_port = 4'(i);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_hdr !== '0) begin errors++; $display("FAIL mid_rst_out_hdr: got %h expected 0", out_hdr); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", in_ready); end
    seen_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    checks++; if (seen_valid !== 0) begin errors++; $display("FAIL mid_fifo_empty: got %0d valid cycles expected 0", seen_valid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  initial begin
    base = {16{32'h12345678}};
    sval = 48'h0050569A0007;
    test_reset();
    test_passthrough();
    test_set_field();
    test_dec_ttl();
    test_drop();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
